// File: rtl/sram_image_packed_if.sv
// Pixel access bus for sram_image_packed: request/write channel, clear pulse,
// and the registered read-return channel.
interface sram_image_packed_if #(
  parameter int PIXEL_DEPTH = 8,
  parameter int XW          = 4,
  parameter int YW          = 4
);
  logic                   req;
  logic                   we;
  logic [XW-1:0]          x_addr;
  logic [YW-1:0]          y_addr;
  logic [PIXEL_DEPTH-1:0] wdat;
  logic                   clr;
  logic                   ready;
  logic                   rvalid;
  logic [PIXEL_DEPTH-1:0] rdat;
  logic                   oob;

  modport master (
    output req, we, x_addr, y_addr, wdat, clr,
    input  ready, rvalid, rdat, oob
  );

  modport slave (
    input  req, we, x_addr, y_addr, wdat, clr,
    output ready, rvalid, rdat, oob
  );
endinterface

// File: rtl/sram_image_packed.sv
// Packed-pixel image store: several pixels per storage word, single-cycle reads
// with a border policy, lane-merging writes and a word-at-a-time array clear.
module sram_image_packed #(
  parameter int                     PIXEL_DEPTH = 8,
  parameter int                     X_MAX       = 5,
  parameter int                     Y_MAX       = 5,
  parameter int                     WORD_WIDTH  = 32,
  parameter int                     BORDER_MODE = 0,
  parameter logic [PIXEL_DEPTH-1:0] BORDER_VAL  = '0
) (
  input logic                ramclk,
  input logic                rst,
  sram_image_packed_if.slave bus
);

  localparam int PX     = WORD_WIDTH / PIXEL_DEPTH;
  localparam int NPIX   = X_MAX * Y_MAX;
  localparam int NWORDS = (NPIX + PX - 1) / PX;
  localparam int XW     = $clog2(X_MAX) + 1;
  localparam int YW     = $clog2(Y_MAX) + 1;
  localparam int WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LW     = (PX > 1) ? $clog2(PX) : 1;
  localparam int OFFW   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [XW-1:0]   X_LIM     = XW'(X_MAX);
  localparam logic [YW-1:0]   Y_LIM     = YW'(Y_MAX);
  localparam logic [XW-1:0]   X_LAST    = XW'(X_MAX - 1);
  localparam logic [YW-1:0]   Y_LAST    = YW'(Y_MAX - 1);
  localparam logic [WW-1:0]   LAST_WORD = WW'(NWORDS - 1);
  localparam logic [OFFW-1:0] PD_W      = OFFW'(PIXEL_DEPTH);

  typedef enum logic [1:0] {IDLE, RMW, CLEAR} state_t;

  state_t                 state;
  logic                   ready_q;
  logic                   rvalid_q;
  logic                   oob_q;
  logic [PIXEL_DEPTH-1:0] rdat_q;
  logic [WW-1:0]          clr_cnt;
  logic [WW-1:0]          wr_word;
  logic [LW-1:0]          wr_lane;
  logic [PIXEL_DEPTH-1:0] wr_dat;

  logic [WORD_WIDTH-1:0]  mem [NWORDS];

  logic                   in_bounds;
  logic [XW-1:0]          x_eff;
  logic [YW-1:0]          y_eff;
  logic [31:0]            lin;
  logic [WW-1:0]          acc_word;
  logic [LW-1:0]          acc_lane;
  logic [OFFW-1:0]        rd_off;
  logic [OFFW-1:0]        wr_off;
  logic [PIXEL_DEPTH-1:0] rd_pix;
  logic [PIXEL_DEPTH-1:0] rd_val;
  logic [WORD_WIDTH-1:0]  merged;

  // Out-of-range coordinates are clamped before addressing, so the storage
  // index is always legal; the border policy then decides what is returned.
  // NOTE: every always_comb output is assigned on all paths (defaults first)
  // so no latches are inferred.
  always_comb begin
    in_bounds = (bus.x_addr < X_LIM) && (bus.y_addr < Y_LIM);
    x_eff     = (bus.x_addr < X_LIM) ? bus.x_addr : X_LAST;
    y_eff     = (bus.y_addr < Y_LIM) ? bus.y_addr : Y_LAST;
    lin       = 32'(x_eff) + 32'(y_eff) * 32'(X_MAX);
    acc_word  = WW'(lin / 32'(PX));
    acc_lane  = LW'(lin % 32'(PX));
    rd_off    = OFFW'(acc_lane) * PD_W;
    rd_pix    = mem[acc_word][rd_off +: PIXEL_DEPTH];
    rd_val    = '0;
    if (in_bounds || BORDER_MODE == 1) begin
      rd_val = rd_pix;
    end else if (BORDER_MODE == 2) begin
      rd_val = BORDER_VAL;
    end
  end

  always_comb begin
    wr_off = OFFW'(wr_lane) * PD_W;
    merged = mem[wr_word];
    merged[wr_off +: PIXEL_DEPTH] = wr_dat;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge ramclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      oob_q    <= 1'b0;
      rdat_q   <= '0;
      clr_cnt  <= '0;
      wr_word  <= '0;
      wr_lane  <= '0;
      wr_dat   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      oob_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr) begin
            state   <= CLEAR;
            ready_q <= 1'b0;
            clr_cnt <= '0;
          end else if (bus.req && ready_q) begin
            if (bus.we) begin
              // Out-of-bounds writes are silently dropped.
              if (in_bounds) begin
                state   <= RMW;
                ready_q <= 1'b0;
                wr_word <= acc_word;
                wr_lane <= acc_lane;
                wr_dat  <= bus.wdat;
              end
            end else begin
              rvalid_q <= 1'b1;
              oob_q    <= !in_bounds;
              rdat_q   <= rd_val;
            end
          end
        end
        RMW: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        CLEAR: begin
          if (clr_cnt == LAST_WORD) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; a reset asserted
  // mid-operation forces IDLE first, so no commit or clear write follows.
  always_ff @(posedge ramclk) begin
    if (state == RMW) begin
      mem[wr_word] <= merged;
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.oob    = oob_q;
  assign bus.rdat   = rdat_q;

endmodule

// File: tb/tb_sram_image_packed.sv
// Bench for sram_image_packed: three instances (border modes 0/1/2) share one
// stimulus stream and are compared every cycle against a pixel-array model.
module tb_sram_image_packed;

  localparam int PD = 8;
  localparam int XM = 5;
  localparam int YM = 5;
  localparam int PX = 4;
  localparam int NW = 7;

  logic       ramclk = 1'b0;
  logic       rst;
  logic       req = 1'b0, we = 1'b0, clr = 1'b0;
  logic [3:0] x_addr = '0, y_addr = '0;
  logic [7:0] wdat = '0;

  logic [2:0]      d_ready, d_rvalid, d_oob;
  logic [2:0][7:0] d_rdat;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 ramclk = ~ramclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_image_packed_if #(.PIXEL_DEPTH(PD), .XW(4), .YW(4)) bus ();
    assign bus.req    = req;
    assign bus.we     = we;
    assign bus.clr    = clr;
    assign bus.x_addr = x_addr;
    assign bus.y_addr = y_addr;
    assign bus.wdat   = wdat;
    assign d_ready[g]  = bus.ready;
    assign d_rvalid[g] = bus.rvalid;
    assign d_oob[g]    = bus.oob;
    assign d_rdat[g]   = bus.rdat;
    sram_image_packed #(
      .PIXEL_DEPTH(PD), .X_MAX(XM), .Y_MAX(YM), .WORD_WIDTH(32),
      .BORDER_MODE(g), .BORDER_VAL(8'h5A)
    ) u_dut (
      .ramclk (ramclk),
      .rst    (rst),
      .bus    (bus)
    );
  end

  // ---------------- behavioural model: flat pixel array ----------------
  logic [7:0]      pix [NW*PX];
  bit              pend_v;
  int              pend_lin;
  logic [7:0]      pend_val;
  int              clr_left;
  logic            e_rvalid, e_oob;
  logic [2:0][7:0] e_rdat;

  function automatic bit inb(int x, int y);
    return (x < XM) && (y < YM);
  endfunction

  function automatic logic [7:0] model_read(int mode, int x, int y);
    if (inb(x, y)) return pix[x + y*XM];
    if (mode == 0) return 8'h00;
    if (mode == 1) return pix[((x < XM) ? x : XM-1) + ((y < YM) ? y : YM-1)*XM];
    return 8'h5A;
  endfunction

  always @(posedge ramclk or posedge rst) begin
    if (rst) begin
      pend_v   <= 1'b0;
      clr_left <= 0;
      e_rvalid <= 1'b0;
      e_oob    <= 1'b0;
      e_rdat   <= '0;
    end else begin
      e_rvalid <= 1'b0;
      e_oob    <= 1'b0;
      if (pend_v) begin
        pix[pend_lin] <= pend_val;
        pend_v        <= 1'b0;
      end else if (clr_left > 0) begin
        for (int k = 0; k < PX; k++) pix[(NW - clr_left)*PX + k] <= 8'h00;
        clr_left <= clr_left - 1;
      end else if (clr) begin
        clr_left <= NW;
      end else if (req) begin
        if (we) begin
          if (inb(int'(x_addr), int'(y_addr))) begin
            pend_v   <= 1'b1;
            pend_lin <= int'(x_addr) + int'(y_addr)*XM;
            pend_val <= wdat;
          end
        end else begin
          e_rvalid <= 1'b1;
          e_oob    <= !inb(int'(x_addr), int'(y_addr));
          for (int m = 0; m < 3; m++) e_rdat[m] <= model_read(m, int'(x_addr), int'(y_addr));
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ramclk) begin
    if (cmp_en) begin
      for (int m = 0; m < 3; m++) begin
        check($sformatf("cyc_ready[%0d]", m), 32'(d_ready[m]), 32'(!pend_v && clr_left == 0));
        check($sformatf("cyc_rvalid[%0d]", m), 32'(d_rvalid[m]), 32'(e_rvalid));
        check($sformatf("cyc_oob[%0d]", m), 32'(d_oob[m]), 32'(e_oob));
        check($sformatf("cyc_rdat[%0d]", m), 32'(d_rdat[m]), 32'(e_rdat[m]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input int x, input int y, input logic [7:0] d);
    @(posedge ramclk); #1;
    req = 1'b1; we = 1'b1; x_addr = 4'(x); y_addr = 4'(y); wdat = d;
    @(posedge ramclk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  // Single read; literal expectations per mode pin both the DUTs and the model.
  task automatic rd_lit(input int x, input int y, input logic [7:0] l0, input logic [7:0] l1,
                        input logic [7:0] l2, input logic lo, input string nm);
    logic [2:0][7:0] lit;
    lit[0] = l0; lit[1] = l1; lit[2] = l2;
    @(posedge ramclk); #1;
    req = 1'b1; we = 1'b0; x_addr = 4'(x); y_addr = 4'(y);
    @(posedge ramclk); #1;
    req = 1'b0;
    for (int m = 0; m < 3; m++) begin
      check($sformatf("%s_rvalid[%0d]", nm, m), 32'(d_rvalid[m]), 32'd1);
      check($sformatf("%s_oob[%0d]", nm, m), 32'(d_oob[m]), 32'(lo));
      check($sformatf("%s_rdat[%0d]", nm, m), 32'(d_rdat[m]), 32'(lit[m]));
      check($sformatf("%s_model[%0d]", nm, m), 32'(e_rdat[m]), 32'(lit[m]));
    end
  endtask

  initial begin
    int cnt;
    logic [7:0] b2b [4];
    b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33; b2b[3] = 8'h44;

    rst = 1'b1;
    repeat (3) @(posedge ramclk);
    #1;
    check("rst_ready", 32'(d_ready[0]), 32'd1);
    check("rst_rvalid", 32'(d_rvalid[0]), 32'd0);
    check("rst_oob", 32'(d_oob[0]), 32'd0);
    check("rst_rdat", 32'(d_rdat[0]), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // clr wins over a simultaneous read; a second clr mid-clear is ignored
    @(posedge ramclk); #1;
    clr = 1'b1; req = 1'b1; we = 1'b0; x_addr = 4'd1; y_addr = 4'd1;
    @(posedge ramclk); #1;
    clr = 1'b0; req = 1'b0;
    check("clr_no_accept", 32'(d_rvalid[0]), 32'd0);
    cnt = 0;
    while (d_ready[0] == 1'b0 && cnt < 20) begin
      cnt++;
      clr = (cnt == 3);
      @(posedge ramclk); #1;
    end
    clr = 1'b0;
    check("clr_busy_cycles", 32'(cnt), 32'd7);
    for (int y = 0; y < YM; y++)
      for (int x = 0; x < XM; x++)
        rd_lit(x, y, 8'h00, 8'h00, 8'h00, 1'b0, "clr_rd");

    // single-lane merge inside word 1
    wr(4, 0, 8'h01); wr(0, 1, 8'h02); wr(1, 1, 8'h03); wr(2, 1, 8'hAB);
    rd_lit(2, 1, 8'hAB, 8'hAB, 8'hAB, 1'b0, "w1_lane3");
    rd_lit(4, 0, 8'h01, 8'h01, 8'h01, 1'b0, "w1_lane0");
    rd_lit(0, 1, 8'h02, 8'h02, 8'h02, 1'b0, "w1_lane1");
    rd_lit(1, 1, 8'h03, 8'h03, 8'h03, 1'b0, "w1_lane2");

    // back-to-back reads of word 0
    wr(0, 0, 8'h11); wr(1, 0, 8'h22); wr(2, 0, 8'h33); wr(3, 0, 8'h44);
    @(posedge ramclk); #1;
    req = 1'b1; we = 1'b0; x_addr = 4'd0; y_addr = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge ramclk); #1;
      check($sformatf("b2b_rvalid%0d", i), 32'(d_rvalid[0]), 32'd1);
      check($sformatf("b2b_rdat%0d", i), 32'(d_rdat[0]), 32'(b2b[i]));
      if (i < 3) x_addr = 4'(i + 1);
      else req = 1'b0;
    end
    @(posedge ramclk); #1;
    check("b2b_end_rvalid", 32'(d_rvalid[0]), 32'd0);

    // border policies and a dropped out-of-bounds write
    wr(4, 2, 8'h77);
    rd_lit(7, 2, 8'h00, 8'h77, 8'h5A, 1'b1, "oob_x");
    rd_lit(2, 9, 8'h00, 8'h00, 8'h5A, 1'b1, "oob_y");
    wr(5, 0, 8'hEE);
    check("oob_wr_ready", 32'(d_ready[0]), 32'd1);
    rd_lit(0, 1, 8'h02, 8'h02, 8'h02, 1'b0, "oob_wr_alias");
    rd_lit(4, 0, 8'h01, 8'h01, 8'h01, 1'b0, "oob_wr_keep");
    rd_lit(5, 0, 8'h00, 8'h01, 8'h5A, 1'b1, "oob_x5");

    // last pixel, read in the first ready cycle
    wr(4, 4, 8'hC3);
    rd_lit(4, 4, 8'hC3, 8'hC3, 8'hC3, 1'b0, "last_pix");

    // reset during RMW leaves the old pixel
    wr(0, 0, 8'h12);
    @(posedge ramclk); #1;
    req = 1'b1; we = 1'b1; x_addr = 4'd0; y_addr = 4'd0; wdat = 8'hFF;
    @(posedge ramclk); #1;
    req = 1'b0; we = 1'b0;
    rst = 1'b1;
    #2;
    check("rmw_rst_rvalid", 32'(d_rvalid[0]), 32'd0);
    check("rmw_rst_oob", 32'(d_oob[0]), 32'd0);
    check("rmw_rst_rdat", 32'(d_rdat[0]), 32'd0);
    @(posedge ramclk); #1;
    rst = 1'b0;
    rd_lit(0, 0, 8'h12, 8'h12, 8'h12, 1'b0, "rmw_rst_keep");

    // reset during CLEAR: words 0-1 cleared, the rest untouched
    wr(2, 2, 8'h66);
    @(posedge ramclk); #1;
    clr = 1'b1;
    @(posedge ramclk); #1;
    clr = 1'b0;
    repeat (2) @(posedge ramclk);
    #1;
    rst = 1'b1;
    @(posedge ramclk); #1;
    rst = 1'b0;
    rd_lit(0, 0, 8'h00, 8'h00, 8'h00, 1'b0, "clr_rst_w0");
    rd_lit(2, 1, 8'h00, 8'h00, 8'h00, 1'b0, "clr_rst_w1");
    rd_lit(2, 2, 8'h66, 8'h66, 8'h66, 1'b0, "clr_rst_w3");
    rd_lit(4, 2, 8'h77, 8'h77, 8'h77, 1'b0, "clr_rst_w3b");
    rd_lit(4, 4, 8'hC3, 8'hC3, 8'hC3, 1'b0, "clr_rst_w6");

    repeat (2) @(posedge ramclk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
